// File: rtl/image_capture_buffer.sv
// image_capture_buffer
// Captures one frame of a two-pixel-per-cycle RGB888 stream into a byte
// buffer laid out as a BMP pixel array (bottom-up rows, BGR byte order),
// with a registered byte read port and frame completion/overflow status.
module image_capture_buffer #(
   parameter int WIDTH  = 256,
   parameter int HEIGHT = 256,
   parameter int AW     = 18
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HSYNC,
   input  logic [7:0]    DATA_R0,
   input  logic [7:0]    DATA_G0,
   input  logic [7:0]    DATA_B0,
   input  logic [7:0]    DATA_R1,
   input  logic [7:0]    DATA_G1,
   input  logic [7:0]    DATA_B1,
   input  logic          clear,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   output logic          capture_done,
   output logic          done_pulse,
   output logic          busy,
   output logic          overflow
);

   localparam int DEPTH = WIDTH * HEIGHT * 3;
   localparam int IW    = $clog2(DEPTH);
   localparam int CW    = $clog2(WIDTH);
   localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   state_t          state;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;
   logic            accept;
   logic            last_beat;
   logic [IW-1:0]   wr_base;
   logic [7:0]      mem [DEPTH];

   // Beat qualification and the byte offset of the even pixel in the buffer
   always_comb begin
      accept    = HSYNC && !clear && (state != ST_DONE);
      last_beat = (row == RW'(HEIGHT - 1)) && (col == CW'(WIDTH - 2));
      wr_base   = IW'(((HEIGHT - 1 - int'(row)) * WIDTH + int'(col)) * 3);
   end

   // Frame buffer write: both pixels (6 bytes) land on the same edge
   always_ff @(posedge HCLK) begin
      if (accept) begin
         mem[wr_base]          <= DATA_B0;
         mem[wr_base + IW'(1)] <= DATA_G0;
         mem[wr_base + IW'(2)] <= DATA_R0;
         mem[wr_base + IW'(3)] <= DATA_B1;
         mem[wr_base + IW'(4)] <= DATA_G1;
         mem[wr_base + IW'(5)] <= DATA_R1;
      end
   end

   // Registered read port; out-of-range addresses return zero
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= ({1'b0, rd_addr} < DEPTH_L) ? mem[rd_addr[IW-1:0]] : '0;
         end
      end
   end

   // Capture FSM with position counters and registered status outputs
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state        <= ST_IDLE;
         col          <= '0;
         row          <= '0;
         capture_done <= 1'b0;
         done_pulse   <= 1'b0;
         busy         <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         if (clear) begin
            state        <= ST_IDLE;
            col          <= '0;
            row          <= '0;
            overflow     <= 1'b0;
            capture_done <= 1'b0;
            busy         <= 1'b0;
         end else if (HSYNC) begin
            case (state)
               ST_IDLE, ST_CAPTURE: begin
                  if (last_beat) begin
                     state        <= ST_DONE;
                     col          <= '0;
                     row          <= '0;
                     capture_done <= 1'b1;
                     done_pulse   <= 1'b1;
                     busy         <= 1'b0;
                  end else begin
                     state <= ST_CAPTURE;
                     busy  <= 1'b1;
                     if (col == CW'(WIDTH - 2)) begin
                        col <= '0;
                        row <= row + RW'(1);
                     end else begin
                        col <= col + CW'(2);
                     end
                  end
               end
               ST_DONE: overflow <= 1'b1;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_image_capture_buffer.sv
// tb_image_capture_buffer
// Directed bench for image_capture_buffer (WIDTH=4, HEIGHT=2) with a
// frame-level reference model checked every cycle plus literal expectations.
module tb_image_capture_buffer;

   localparam int W     = 4;
   localparam int H     = 2;
   localparam int AW    = 5;
   localparam int DEPTH = W * H * 3;
   localparam int NB    = W * H / 2;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          HSYNC = 1'b0;
   logic [7:0]    DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
   logic [7:0]    DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
   logic          clear = 1'b0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [7:0]    rd_data;
   logic          rd_valid, capture_done, done_pulse, busy, overflow;

   image_capture_buffer #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(HSYNC),
      .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
      .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
      .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .capture_done(capture_done),
      .done_pulse(done_pulse), .busy(busy), .overflow(overflow)
   );

   always #5 HCLK = ~HCLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame position is a beat count, pixel coordinates derived arithmetically
   logic [7:0] mm [DEPTH];
   bit         mk [DEPTH];
   int         m_n = 0;
   bit         m_done = 0, m_ovf = 0, m_pulse = 0, m_rv = 0, m_rk = 1;
   logic [7:0] m_rd = '0;
   int         p, r, c, base;

   initial for (int i = 0; i < DEPTH; i++) mk[i] = 0;

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         m_n = 0; m_done = 0; m_ovf = 0; m_pulse = 0;
         m_rv = 0; m_rd = '0; m_rk = 1;
      end else begin
         m_rv = rd_en;
         if (rd_en) begin
            if (int'(rd_addr) >= DEPTH) begin
               m_rd = '0; m_rk = 1;
            end else begin
               m_rd = mm[rd_addr]; m_rk = mk[rd_addr];
            end
         end
         m_pulse = 0;
         if (clear) begin
            m_n = 0; m_done = 0; m_ovf = 0;
         end else if (HSYNC) begin
            if (m_done) begin
               m_ovf = 1;
            end else begin
               p = 2 * m_n;
               r = p / W;
               c = p % W;
               base = ((H - 1 - r) * W + c) * 3;
               mm[base]   = DATA_B0; mm[base+1] = DATA_G0; mm[base+2] = DATA_R0;
               mm[base+3] = DATA_B1; mm[base+4] = DATA_G1; mm[base+5] = DATA_R1;
               for (int i = 0; i < 6; i++) mk[base+i] = 1;
               m_n++;
               if (m_n == NB) begin
                  m_done = 1; m_pulse = 1;
               end
            end
         end
      end
   end

   // Compare DUT outputs against the model on every falling edge
   always @(negedge HCLK) begin
      chk("capture_done", capture_done, m_done);
      chk("done_pulse", done_pulse, m_pulse);
      chk("busy", busy, (m_n > 0 && !m_done));
      chk("overflow", overflow, m_ovf);
      chk("rd_valid", rd_valid, m_rv);
      if (m_rk) chk("rd_data", rd_data, m_rd);
   end

   task automatic beat(input logic [7:0] r0, g0, b0, r1, g1, b1);
      HSYNC = 1'b1;
      DATA_R0 = r0; DATA_G0 = g0; DATA_B0 = b0;
      DATA_R1 = r1; DATA_G1 = g1; DATA_B1 = b1;
      @(negedge HCLK);
      HSYNC = 1'b0;
   endtask

   task automatic std_beat(input int k, input logic [7:0] o);
      beat(8'h10 + 8'(k) + o, 8'h20 + 8'(k) + o, 8'h30 + 8'(k) + o,
           8'h40 + 8'(k) + o, 8'h50 + 8'(k) + o, 8'h60 + 8'(k) + o);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge HCLK);
   endtask

   task automatic rd(input int addr, output logic [7:0] d, output logic v);
      rd_en = 1'b1;
      rd_addr = AW'(addr);
      @(negedge HCLK);
      d = rd_data;
      v = rd_valid;
      rd_en = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge HCLK);
      clear = 1'b0;
   endtask

   logic [7:0] t_hi [12];
   logic [7:0] t_lo [6];
   logic [7:0] d;
   logic       v;

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      t_hi = '{8'h30, 8'h20, 8'h10, 8'h60, 8'h50, 8'h40,
               8'h31, 8'h21, 8'h11, 8'h61, 8'h51, 8'h41};
      t_lo = '{8'h32, 8'h22, 8'h12, 8'h62, 8'h52, 8'h42};

      // Reset state
      idle(2);
      chk("rst_done", capture_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      HRESETn = 1'b1;
      idle(1);

      // 1: back-to-back frame
      for (int k = 0; k < NB; k++) begin
         std_beat(k, 8'h00);
         if (k < NB - 1) chk("t1_no_early_pulse", done_pulse, 0);
      end
      chk("t1_done_pulse", done_pulse, 1);
      chk("t1_capture_done", capture_done, 1);
      idle(1);
      chk("t1_pulse_one_cycle", done_pulse, 0);
      for (int i = 0; i < 6; i++) begin
         rd(12 + i, d, v); chk("t1_hi_byte", d, t_hi[i]);
         rd(i, d, v);      chk("t1_lo_byte", d, t_lo[i]);
      end

      // 2: same frame with gaps
      pulse_clear();
      chk("t2_cleared", capture_done, 0);
      for (int k = 0; k < NB; k++) begin
         std_beat(k, 8'h00);
         if (k < NB - 1) begin
            chk("t2_busy", busy, 1);
            idle(3);
         end
      end
      chk("t2_done", capture_done, 1);
      for (int i = 0; i < 6; i++) begin
         rd(12 + i, d, v); chk("t2_hi_byte", d, t_hi[i]);
         rd(i, d, v);      chk("t2_lo_byte", d, t_lo[i]);
      end

      // 3: beat after done
      beat(8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
      chk("t3_overflow", overflow, 1);
      idle(3);
      chk("t3_overflow_sticky", overflow, 1);
      for (int i = 0; i < 12; i++) begin
         rd(12 + i, d, v); chk("t3_unchanged", d, t_hi[i]);
      end
      pulse_clear();
      chk("t3_clear_ovf", overflow, 0);
      chk("t3_clear_done", capture_done, 0);

      // 4: clear beats HSYNC in IDLE
      clear = 1'b1;
      beat(8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
      clear = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_done", capture_done, 0);
      rd(12, d, v); chk("t4_not_written", d, 8'h30);
      beat(8'hA3, 8'hA2, 8'hA1, 8'hA6, 8'hA5, 8'hA4);
      chk("t4_busy_after", busy, 1);
      rd(12, d, v); chk("t4_row0_col0_b0", d, 8'hA1);
      rd(17, d, v); chk("t4_row0_col0_r1", d, 8'hA6);

      // 5: reset mid-frame
      std_beat(1, 8'h00);
      #2 HRESETn = 1'b0;
      #1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_done", capture_done, 0);
      chk("t5_rst_pulse", done_pulse, 0);
      chk("t5_rst_ovf", overflow, 0);
      chk("t5_rst_rv", rd_valid, 0);
      chk("t5_rst_rd", rd_data, 0);
      @(negedge HCLK);
      idle(1);
      #2 HRESETn = 1'b1;
      @(negedge HCLK);
      for (int k = 0; k < NB; k++) begin
         std_beat(k, 8'h80);
         chk("t5_done", capture_done, (k == NB - 1));
      end
      rd(12, d, v); chk("t5_restart_row0", d, 8'hB0);
      rd(0, d, v);  chk("t5_row1", d, 8'hB2);

      // Read-before-write on the same edge
      pulse_clear();
      rd_en = 1'b1;
      rd_addr = AW'(12);
      beat(8'h11, 8'h22, 8'h5A, 8'h44, 8'h55, 8'h66);
      rd_en = 1'b0;
      chk("rbw_old_byte", rd_data, 8'hB0);
      rd(12, d, v); chk("rbw_new_byte", d, 8'h5A);

      // 6: out-of-range read
      rd(24, d, v);
      chk("t6_valid", v, 1);
      chk("t6_zero", d, 0);
      idle(1);
      chk("t6_valid_low", rd_valid, 0);
      chk("t6_hold", rd_data, 0);

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
